// File: rtl/sobel_window_ctrl_if.sv
// Column-stream and result-handshake bundle of the Sobel window controller.
interface sobel_window_ctrl_if;
  logic        col_valid;
  logic [23:0] col_in;
  logic        col_ready;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_col;
  logic [9:0]  out_row;

  modport master (
    output col_valid, col_in, out_ready,
    input  col_ready, out_valid, out_col, out_row
  );

  modport slave (
    input  col_valid, col_in, out_ready,
    output col_ready, out_valid, out_col, out_row
  );
endinterface

// File: rtl/sobel_window_ctrl.sv
// Sobel window sequencer: shifts pixel columns into a 3x4 buffer, strobes gx/gy calc, tracks position.
// Optional SOBEL_CTRL_ERR_EN adds err/err_seen protocol-violation outputs.
module sobel_window_ctrl #(
  parameter int unsigned IMG_WIDTH = 640,
  parameter int unsigned OUT_ROWS  = 478
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  sobel_window_ctrl_if.slave bus,
  output logic [11:0][7:0] data_buffer,
  output logic             enable_calc,
  output logic             line_done,
  output logic             frame_done,
  output logic             busy
`ifdef SOBEL_CTRL_ERR_EN
  ,
  output logic             err,
  output logic             err_seen
`endif
);

  localparam int unsigned CW = 10;
  localparam logic [CW-1:0] LAST_COL     = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] LAST_OUT_COL = CW'(IMG_WIDTH - 3);
  localparam logic [CW-1:0] LAST_ROW     = CW'(OUT_ROWS - 1);

  typedef enum logic [1:0] {IDLE, RUN, CALC} state_t;

  state_t          state;
  logic [CW-1:0]   ccnt;
  logic [CW-1:0]   rcnt;
  logic            out_valid;
  logic [CW-1:0]   out_col;
  logic [CW-1:0]   out_row;
  logic            col_ready_c;
  logic            accept;
  logic            handshake;
  logic            last_pair;
  logic            calc_hit;

  assign col_ready_c = (state == RUN) && (!out_valid || bus.out_ready);
  assign accept      = bus.col_valid && col_ready_c;
  assign handshake   = out_valid && bus.out_ready;
  assign last_pair   = (out_row == LAST_ROW) && (out_col == LAST_OUT_COL);
  // ccnt holds the index of the column being accepted; odd index >= 3 completes a window pair
  assign calc_hit    = (ccnt >= CW'(3)) && ccnt[0];

  assign bus.col_ready = col_ready_c;
  assign bus.out_valid = out_valid;
  assign bus.out_col   = out_col;
  assign bus.out_row   = out_row;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      ccnt        <= '0;
      rcnt        <= '0;
      out_valid   <= 1'b0;
      out_col     <= '0;
      out_row     <= '0;
      data_buffer <= '0;
      enable_calc <= 1'b0;
      line_done   <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
`ifdef SOBEL_CTRL_ERR_EN
      err         <= 1'b0;
      err_seen    <= 1'b0;
`endif
    end else begin
      enable_calc <= 1'b0;
      line_done   <= 1'b0;
      frame_done  <= 1'b0;
`ifdef SOBEL_CTRL_ERR_EN
      err      <= (start && busy) || (bus.col_valid && (state == IDLE));
      err_seen <= err_seen || (start && busy) || (bus.col_valid && (state == IDLE));
`endif
      if (start) begin
        // start from any state (re)opens a frame and drops any pending result
        state     <= RUN;
        ccnt      <= '0;
        rcnt      <= '0;
        out_valid <= 1'b0;
        busy      <= 1'b1;
      end else begin
        if (handshake) begin
          out_valid <= 1'b0;
          if (last_pair) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end
        end
        case (state)
          IDLE: ;
          RUN: begin
            if (accept) begin
              for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                  data_buffer[4*r+c] <= data_buffer[4*r+c+1];
                end
                data_buffer[4*r+3] <= bus.col_in[8*r +: 8];
              end
              ccnt <= ccnt + CW'(1);
              if (calc_hit) begin
                state       <= CALC;
                enable_calc <= 1'b1;
                line_done   <= (ccnt == LAST_COL);
              end
            end
          end
          CALC: begin
            // ccnt was already advanced past the accepted column
            state     <= RUN;
            out_valid <= 1'b1;
            out_col   <= ccnt - CW'(3);
            out_row   <= rcnt;
            if (line_done) begin
              ccnt <= '0;
              rcnt <= rcnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
        if (handshake && last_pair) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Randomized bench for sobel_window_ctrl: three geometries, each scored by a per-instance frame model.
module tb_sobel_window_ctrl;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start_d     [3];
  logic        col_valid_d [3];
  logic [23:0] col_in_d    [3];
  int          ready_mode  [3];
  logic [2:0]  col_ready_o;
  logic [2:0]  busy_o;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int unsigned W = (g == 0) ? 8 : ((g == 1) ? 4 : 12);
    localparam int unsigned R = (g == 0) ? 1 : ((g == 1) ? 3 : 2);

    sobel_window_ctrl_if bus ();
    logic [11:0][7:0] data_buffer;
    logic             enable_calc, line_done, frame_done, busy;
    logic             err, err_seen;
    logic             rdy = 1'b1;

    assign bus.col_valid = col_valid_d[g];
    assign bus.col_in    = col_in_d[g];
    assign bus.out_ready = rdy;
    assign col_ready_o[g] = bus.col_ready;
    assign busy_o[g]      = busy;
`ifndef SOBEL_CTRL_ERR_EN
    assign err      = 1'b0;
    assign err_seen = 1'b0;
`endif

    sobel_window_ctrl #(.IMG_WIDTH(W), .OUT_ROWS(R)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .start       (start_d[g]),
      .bus         (bus),
      .data_buffer (data_buffer),
      .enable_calc (enable_calc),
      .line_done   (line_done),
      .frame_done  (frame_done),
      .busy        (busy)
`ifdef SOBEL_CTRL_ERR_EN
      ,
      .err         (err),
      .err_seen    (err_seen)
`endif
    );

    always @(posedge clk) begin
      #1;
      case (ready_mode[g])
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b0;
      endcase
    end

    // Frame model: columns counted per line, pair list built from the frame geometry.
    bit          in_frame, calc_due, ld_due, exp_valid, fd_due, err_due, seen_due;
    bit          exp_rdy, hs, acc;
    int          n_acc, pend_r, pend_c, ec_dut;
    logic [23:0] hist[$];
    int          pairs_r[$], pairs_c[$];
    logic [95:0] exp_buf;

    always @(negedge clk) begin
      if (!n_rst) begin
        in_frame = 0; calc_due = 0; ld_due = 0; exp_valid = 0; fd_due = 0;
        err_due = 0; seen_due = 0; n_acc = 0; ec_dut = 0;
        hist.delete(); pairs_r.delete(); pairs_c.delete();
        check_val("rst_buffer", 96'(data_buffer), 96'd0);
        check_val("rst_out_col", 96'(bus.out_col), 96'd0);
        check_val("rst_out_row", 96'(bus.out_row), 96'd0);
      end
      exp_rdy = in_frame && !calc_due && (!exp_valid || rdy);
      check_val("col_ready", 96'(bus.col_ready), 96'(exp_rdy));
      check_val("enable_calc", 96'(enable_calc), 96'(calc_due));
      check_val("line_done", 96'(line_done), 96'(calc_due && ld_due));
      check_val("out_valid", 96'(bus.out_valid), 96'(exp_valid));
      check_val("frame_done", 96'(frame_done), 96'(fd_due));
      check_val("busy", 96'(busy), 96'(in_frame));
`ifdef SOBEL_CTRL_ERR_EN
      check_val("err", 96'(err), 96'(err_due));
      check_val("err_seen", 96'(err_seen), 96'(seen_due));
`endif
      if (calc_due) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 3; r++)
            exp_buf[8*(4*r+c) +: 8] = hist[hist.size()-4+c][8*r +: 8];
        check_val("buffer", 96'(data_buffer), exp_buf);
      end
      if (exp_valid) begin
        check_val("out_col", 96'(bus.out_col), 96'(pend_c));
        check_val("out_row", 96'(bus.out_row), 96'(pend_r));
      end
      if (enable_calc) ec_dut++;

      if (n_rst) begin
        hs  = exp_valid && rdy;
        acc = exp_rdy && col_valid_d[g];
        err_due  = (start_d[g] && in_frame) || (col_valid_d[g] && !in_frame);
        seen_due = seen_due || err_due;
        fd_due = 0;
        if (start_d[g]) begin
          in_frame = 1; n_acc = 0; calc_due = 0; ld_due = 0; exp_valid = 0; ec_dut = 0;
          hist.delete(); pairs_r.delete(); pairs_c.delete();
          for (int r = 0; r < int'(R); r++)
            for (int c = 1; c <= int'(W) - 3; c += 2) begin
              pairs_r.push_back(r);
              pairs_c.push_back(c);
            end
        end else begin
          if (hs) begin
            exp_valid = 0;
            if (pairs_r.size() == 0) begin
              fd_due = 1;
              in_frame = 0;
              check_val("calc_count", 96'(ec_dut), 96'(R * (W - 2) / 2));
            end
          end
          if (calc_due) begin
            exp_valid = 1;
            if (pairs_r.size() == 0) check_val("pair_overflow", 96'd1, 96'd0);
            else begin
              pend_r = pairs_r.pop_front();
              pend_c = pairs_c.pop_front();
            end
            if (ld_due) n_acc = 0;
            calc_due = 0;
            ld_due = 0;
          end else if (acc) begin
            hist.push_back(col_in_d[g]);
            if (hist.size() > 4) void'(hist.pop_front());
            if (n_acc >= 3 && (n_acc % 2) == 1) begin
              calc_due = 1;
              ld_due = (n_acc == int'(W) - 1);
            end
            n_acc++;
          end
        end
      end
    end
  end

  // All driver tasks are entered and left one time unit after a rising edge.
  task automatic pulse_start(input int g);
    start_d[g] = 1'b1;
    @(posedge clk); #1;
    start_d[g] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_try(input int g, input logic [23:0] c, input int budget, output bit ok);
    bit r;
    ok = 1'b0;
    col_valid_d[g] = 1'b1;
    col_in_d[g] = c;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); r = col_ready_o[g];
      @(posedge clk); #1;
      if (r) begin ok = 1'b1; break; end
    end
    col_valid_d[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    bit done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy_o[g]) begin done = 1'b1; break; end
    end
    @(posedge clk); #1;
    check_val("idle_timeout", 96'(done), 96'd1);
  endtask

  function automatic logic [23:0] pat_col(input int k);
    return {8'(3*k+2), 8'(3*k+1), 8'(3*k)};
  endfunction

  task automatic send_cols(input int g, input int first, input int last, input bit pat);
    bit ok;
    for (int k = first; k <= last; k++) begin
      send_try(g, pat ? pat_col(k) : 24'($urandom), 500, ok);
      if (!ok) begin
        check_val("col_timeout", 96'd0, 96'd1);
        return;
      end
    end
  endtask

  task automatic run_frame(input int g, input int w, input int rows, input bit pat);
    pulse_start(g);
    for (int r = 0; r < rows; r++) send_cols(g, 0, w - 1, pat);
    wait_idle(g);
  endtask

  initial begin
    bit ok;
    int n_bp;
    for (int g = 0; g < 3; g++) begin
      start_d[g] = 0; col_valid_d[g] = 0; col_in_d[g] = '0; ready_mode[g] = 0;
    end
    idle_cycles(3);
    n_rst = 1'b1;
    idle_cycles(2);

    // known-pattern single-line frame, downstream always ready
    run_frame(0, 8, 1, 1'b1);
    check_val("frame0_idle", 96'(busy_o[0]), 96'd0);

    // random pixels with random downstream stalls
    ready_mode[0] = 1;
    repeat (3) run_frame(0, 8, 1, 1'b0);

    // backpressure: stall right after the first result, then release
    ready_mode[0] = 0;
    pulse_start(0);
    send_cols(0, 0, 3, 1'b0);
    ready_mode[0] = 2;
    n_bp = 0;
    for (int k = 4; k < 8; k++) begin
      send_try(0, 24'($urandom), 20, ok);
      if (!ok) break;
      n_bp++;
    end
    check_val("bp_accepts_le2", 96'(n_bp <= 2), 96'd1);
    ready_mode[0] = 0;
    send_cols(0, 4 + n_bp, 7, 1'b0);
    wait_idle(0);

    // multi-row frames on the 4-wide geometry
    run_frame(1, 4, 3, 1'b0);
    ready_mode[1] = 1;
    run_frame(1, 4, 3, 1'b0);
    check_val("multi_idle", 96'(busy_o[1]), 96'd0);

    // stray column while idle is ignored
    col_valid_d[1] = 1'b1;
    col_in_d[1] = 24'($urandom);
    idle_cycles(1);
    col_valid_d[1] = 1'b0;
    idle_cycles(2);

    // restart after five columns, then a full frame
    ready_mode[2] = 1;
    pulse_start(2);
    send_cols(2, 0, 4, 1'b0);
    pulse_start(2);
    for (int r = 0; r < 2; r++) send_cols(2, 0, 11, 1'b0);
    wait_idle(2);
    repeat (2) run_frame(2, 12, 2, 1'b0);

    // asynchronous reset with a result pending
    ready_mode[0] = 2;
    pulse_start(0);
    send_cols(0, 0, 3, 1'b0);
    idle_cycles(2);
    #2 n_rst = 1'b0;
    @(negedge clk);
    check_val("rst_busy", 96'(busy_o[0]), 96'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    ready_mode[0] = 0;
    idle_cycles(2);
    run_frame(0, 8, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
